// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player: FSM states, note payload
// and the octave-5 phase-increment table.
package note_player_pkg;

  localparam int unsigned PITCH_W    = 6;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned INSTR_W    = 4;
  localparam int unsigned OCT_W      = 3;
  localparam int unsigned SEMI_W     = 4;
  localparam int unsigned BASE_W     = 16;
  localparam int unsigned PITCH_REST = 0;
  localparam int unsigned SEMITONES  = 12;
  localparam int unsigned MAX_OCT    = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_WAIT_NOTE = 3'd2,
    ST_DECODE    = 3'd3,
    ST_PLAY      = 3'd4
  } state_e;

  typedef struct packed {
    logic [PITCH_W-1:0] pitch;
    logic [LEN_W-1:0]   len;
    logic [INSTR_W-1:0] instrument;
  } note_t;

  // Equal-tempered octave-5 increments, C = 0x8000
  function automatic logic [BASE_W-1:0] base_phase(input logic [SEMI_W-1:0] semi);
    case (semi)
      4'd0:    base_phase = 16'd32768;
      4'd1:    base_phase = 16'd34716;
      4'd2:    base_phase = 16'd36781;
      4'd3:    base_phase = 16'd38968;
      4'd4:    base_phase = 16'd41285;
      4'd5:    base_phase = 16'd43740;
      4'd6:    base_phase = 16'd46341;
      4'd7:    base_phase = 16'd49097;
      4'd8:    base_phase = 16'd52016;
      4'd9:    base_phase = 16'd55109;
      4'd10:   base_phase = 16'd58386;
      4'd11:   base_phase = 16'd61858;
      default: base_phase = '0;
    endcase
  endfunction

endpackage

// File: rtl/note_player_pitch_decoder.sv
// Iterative pitch-to-phase converter: repeated subtract-12 yields semitone and
// octave, then the octave-5 table entry is shifted down by the octave deficit.
module pitch_decoder
  import note_player_pkg::*;
#(
  parameter int unsigned PHASE_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [PITCH_W-1:0] i_pitch,
  output logic               o_done_c,
  output logic [PHASE_W-1:0] o_phase_inc_c
);

  logic [PITCH_W-1:0] r_q, r_d;
  logic [OCT_W-1:0]   oct_q, oct_d;
  logic               busy_q, busy_d;
  logic               rest_q, rest_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= '0;
      oct_q  <= '0;
      busy_q <= 1'b0;
      rest_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      oct_q  <= oct_d;
      busy_q <= busy_d;
      rest_q <= rest_d;
    end
  end

  always_comb begin
    r_d    = r_q;
    oct_d  = oct_q;
    busy_d = busy_q;
    rest_d = rest_q;
    if (i_abort) begin
      busy_d = 1'b0;
    end else if (i_start) begin
      rest_d = (i_pitch == PITCH_W'(PITCH_REST));
      r_d    = rest_d ? '0 : i_pitch - PITCH_W'(1);
      oct_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (r_q >= PITCH_W'(SEMITONES)) begin
        r_d   = r_q - PITCH_W'(SEMITONES);
        oct_d = oct_q + OCT_W'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  assign o_done_c      = busy_q && (r_q < PITCH_W'(SEMITONES));
  assign o_phase_inc_c = rest_q ? '0
                       : PHASE_W'(base_phase(r_q[SEMI_W-1:0])) >> (OCT_W'(MAX_OCT) - oct_q);

endmodule

// File: rtl/note_player.sv
// Note-interface consumer: requests notes from the sequencer, decodes pitch
// to a phase increment and holds gate/frequency/instrument for len+1 ticks.
module note_player
  import note_player_pkg::*;
#(
  parameter int unsigned PHASE_W        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ARTIC          = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_tick,
  output logic               o_note_stb,
  input  logic               i_note_valid,
  input  logic [PITCH_W-1:0] i_note_pitch,
  input  logic [LEN_W-1:0]   i_note_len,
  input  logic [INSTR_W-1:0] i_note_instrument,
  output logic               o_gate,
  output logic [PHASE_W-1:0] o_phase_inc,
  output logic [INSTR_W-1:0] o_instrument,
  output logic               o_note_start,
  output logic               o_timeout
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [LEN_W-1:0]   tick_cnt_q, tick_cnt_d;
  note_t              note_q, note_d;
  logic               stb_q, stb_d;
  logic               timeout_q, timeout_d;
  logic               note_start_q, note_start_d;
  logic               gate_q, gate_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  logic               dec_start;
  logic               dec_done_c;
  logic [PHASE_W-1:0] dec_phase_c;

  assign dec_start = i_enable && (state_q == ST_WAIT_NOTE) && i_note_valid;

  pitch_decoder #(.PHASE_W(PHASE_W)) u_pitch_decoder (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (dec_start),
    .i_abort       (!i_enable),
    .i_pitch       (i_note_pitch),
    .o_done_c      (dec_done_c),
    .o_phase_inc_c (dec_phase_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; dropping enable overrides every other event
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_REQUEST;
        ST_REQUEST:   state_d = ST_WAIT_NOTE;
        ST_WAIT_NOTE: if (i_note_valid)            state_d = ST_DECODE;
                      else if (to_cnt_q == '0)     state_d = ST_REQUEST;
        ST_DECODE:    if (dec_done_c)              state_d = ST_PLAY;
        ST_PLAY:      if (i_tick && tick_cnt_q == '0) state_d = ST_REQUEST;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    to_cnt_d     = to_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    note_d       = note_q;
    stb_d        = 1'b0;
    timeout_d    = 1'b0;
    note_start_d = 1'b0;
    phase_d      = phase_q;
    instr_d      = instr_q;
    if (!i_enable) begin
      phase_d = '0;
    end else begin
      case (state_q)
        ST_REQUEST: begin
          stb_d    = 1'b1;
          to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
        end
        ST_WAIT_NOTE: begin
          if (i_note_valid) begin
            note_d = '{pitch: i_note_pitch, len: i_note_len, instrument: i_note_instrument};
          end else if (to_cnt_q == '0) begin
            timeout_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q - TO_W'(1);
          end
        end
        ST_DECODE: begin
          if (dec_done_c) begin
            phase_d      = dec_phase_c;
            instr_d      = note_q.instrument;
            tick_cnt_d   = note_q.len;
            note_start_d = 1'b1;
          end
        end
        ST_PLAY: begin
          if (i_tick && tick_cnt_q != '0) tick_cnt_d = tick_cnt_q - LEN_W'(1);
        end
        default: ;
      endcase
    end
    // Articulation: silence the last tick of multi-tick notes
    gate_d = (state_d == ST_PLAY) && (note_q.pitch != PITCH_W'(PITCH_REST))
          && !((ARTIC != 0) && (note_q.len != '0) && (tick_cnt_d == '0));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt_q     <= '0;
      tick_cnt_q   <= '0;
      note_q       <= '0;
      stb_q        <= 1'b0;
      timeout_q    <= 1'b0;
      note_start_q <= 1'b0;
      gate_q       <= 1'b0;
      phase_q      <= '0;
      instr_q      <= '0;
    end else begin
      to_cnt_q     <= to_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      note_q       <= note_d;
      stb_q        <= stb_d;
      timeout_q    <= timeout_d;
      note_start_q <= note_start_d;
      gate_q       <= gate_d;
      phase_q      <= phase_d;
      instr_q      <= instr_d;
    end
  end

  assign o_note_stb   = stb_q;
  assign o_timeout    = timeout_q;
  assign o_note_start = note_start_q;
  assign o_gate       = gate_q;
  assign o_phase_inc  = phase_q;
  assign o_instrument = instr_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: request timing, decode latency, gate shaping,
// timeouts, enable handling and a multi-note responder sequence.
module tb_note_player;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_tick;
  logic        i_note_valid;
  logic [5:0]  i_note_pitch;
  logic [4:0]  i_note_len;
  logic [3:0]  i_note_instrument;
  logic        o_note_stb;
  logic        o_gate;
  logic [15:0] o_phase_inc;
  logic [3:0]  o_instrument;
  logic        o_note_start;
  logic        o_timeout;

  int n_vec = 0;
  int n_err = 0;
  int stb_seen = 0;
  int to_seen = 0;
  int start_seen = 0;

  note_player #(.PHASE_W(16), .TIMEOUT_CYCLES(16), .ARTIC(1)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_enable          (i_enable),
    .i_tick            (i_tick),
    .o_note_stb        (o_note_stb),
    .i_note_valid      (i_note_valid),
    .i_note_pitch      (i_note_pitch),
    .i_note_len        (i_note_len),
    .i_note_instrument (i_note_instrument),
    .o_gate            (o_gate),
    .o_phase_inc       (o_phase_inc),
    .o_instrument      (o_instrument),
    .o_note_start      (o_note_start),
    .o_timeout         (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_note_stb === 1'b1)   stb_seen++;
    if (o_timeout === 1'b1)    to_seen++;
    if (o_note_start === 1'b1) start_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  function automatic logic [15:0] tb_base(input int s);
    case (s)
      0: return 16'd32768;   1: return 16'd34716;   2: return 16'd36781;
      3: return 16'd38968;   4: return 16'd41285;   5: return 16'd43740;
      6: return 16'd46341;   7: return 16'd49097;   8: return 16'd52016;
      9: return 16'd55109;  10: return 16'd58386;  11: return 16'd61858;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] exp_phase(input int p);
    if (p == 0) return 16'd0;
    return tb_base((p - 1) % 12) >> (5 - (p - 1) / 12);
  endfunction

  function automatic int exp_lat(input int p);
    return (p == 0) ? 2 : (p - 1) / 12 + 2;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_note(input int p, input int l, input int ins);
    i_note_pitch      = 6'(p);
    i_note_len        = 5'(l);
    i_note_instrument = 4'(ins);
    i_note_valid      = 1'b1;
    step();
    i_note_valid      = 1'b0;
  endtask

  task automatic tick_once();
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
  endtask

  // Cycles until o_note_stb is seen, -1 if the budget runs out
  task automatic wait_stb(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (o_note_stb === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Called one cycle after the valid cycle; returns valid-to-start latency
  task automatic wait_start(input int max_cyc, output int n);
    n = 1;
    while (o_note_start !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    if (o_note_start !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_enable = 1'b0; i_tick = 1'b0; i_note_valid = 1'b0;
    i_note_pitch = '0; i_note_len = '0; i_note_instrument = '0;
    repeat (3) step();
    n_vec++; if ({o_note_stb, o_gate, o_note_start, o_timeout} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {o_note_stb, o_gate, o_note_start, o_timeout});
    end
    n_vec++; if (o_phase_inc !== 16'd0 || o_instrument !== 4'd0) begin
      n_err++; $display("FAIL reset_data: got phase %0d instr %0d expected 0 0", o_phase_inc, o_instrument);
    end
    i_rst = 1'b0;
    repeat (3) step();
    n_vec++; if (stb_seen !== 0) begin
      n_err++; $display("FAIL idle_no_stb: got %0d strobes expected 0", stb_seen);
    end
  endtask

  task automatic test_first_note();
    int n;
    i_enable = 1'b1;
    wait_stb(10, n);
    n_vec++; if (n !== 2) begin
      n_err++; $display("FAIL first_stb_delay: got %0d expected 2", n);
    end
    n_vec++; if (o_gate !== 1'b0 || o_phase_inc !== 16'd0) begin
      n_err++; $display("FAIL req_outputs: got gate %b phase %0d expected 0 0", o_gate, o_phase_inc);
    end
    send_note(13, 2, 5);
    wait_start(20, n);
    n_vec++; if (n !== 3) begin
      n_err++; $display("FAIL lat_p13: got %0d expected 3", n);
    end
    n_vec++; if (o_phase_inc !== 16'd2048 || o_instrument !== 4'd5 || o_gate !== 1'b1) begin
      n_err++; $display("FAIL start_p13: got phase %0d instr %0d gate %b expected 2048 5 1", o_phase_inc, o_instrument, o_gate);
    end
    step();
    tick_once();
    n_vec++; if (o_gate !== 1'b1) begin
      n_err++; $display("FAIL gate_tick1: got %b expected 1", o_gate);
    end
    step();
    tick_once();
    n_vec++; if (o_gate !== 1'b0) begin
      n_err++; $display("FAIL gate_tick2_artic: got %b expected 0", o_gate);
    end
    step();
    tick_once();
    n_vec++; if (o_note_stb !== 1'b0 || o_gate !== 1'b0) begin
      n_err++; $display("FAIL after_tick3: got stb %b gate %b expected 0 0", o_note_stb, o_gate);
    end
    step();
    n_vec++; if (o_note_stb !== 1'b1 || o_phase_inc !== 16'd2048) begin
      n_err++; $display("FAIL stb_after_tick3: got stb %b phase %0d expected 1 2048", o_note_stb, o_phase_inc);
    end
  endtask

  task automatic test_rest_and_top();
    int n;
    send_note(0, 0, 3);
    wait_start(20, n);
    n_vec++; if (n !== 2 || o_phase_inc !== 16'd0 || o_gate !== 1'b0 || o_instrument !== 4'd3) begin
      n_err++; $display("FAIL rest_note: got lat %0d phase %0d gate %b instr %0d expected 2 0 0 3", n, o_phase_inc, o_gate, o_instrument);
    end
    tick_once();
    step();
    n_vec++; if (o_note_stb !== 1'b1) begin
      n_err++; $display("FAIL rest_one_tick: got stb %b expected 1", o_note_stb);
    end
    send_note(63, 0, 9);
    wait_start(20, n);
    n_vec++; if (n !== 7 || o_phase_inc !== 16'd36781 || o_gate !== 1'b1 || o_instrument !== 4'd9) begin
      n_err++; $display("FAIL pitch63: got lat %0d phase %0d gate %b instr %0d expected 7 36781 1 9", n, o_phase_inc, o_gate, o_instrument);
    end
    tick_once();
    step();
    n_vec++; if (o_note_stb !== 1'b1) begin
      n_err++; $display("FAIL p63_len0_stb: got %b expected 1", o_note_stb);
    end
  endtask

  task automatic test_timeout();
    int n;
    int early;
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (o_timeout === 1'b1 || o_note_stb === 1'b1) early++;
    end
    n_vec++; if (early !== 0) begin
      n_err++; $display("FAIL timeout_early: got %0d events expected 0", early);
    end
    step();
    n_vec++; if (o_timeout !== 1'b1 || o_note_stb !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse: got to %b stb %b expected 1 0", o_timeout, o_note_stb);
    end
    step();
    n_vec++; if (o_note_stb !== 1'b1 || o_timeout !== 1'b0) begin
      n_err++; $display("FAIL retry_stb: got stb %b to %b expected 1 0", o_note_stb, o_timeout);
    end
    // Valid on the expiry cycle must win over the timeout
    repeat (15) step();
    send_note(1, 0, 1);
    n_vec++; if (o_timeout !== 1'b0) begin
      n_err++; $display("FAIL expiry_valid_to: got %b expected 0", o_timeout);
    end
    wait_start(20, n);
    n_vec++; if (n !== 2 || o_phase_inc !== 16'd1024 || o_instrument !== 4'd1) begin
      n_err++; $display("FAIL expiry_note: got lat %0d phase %0d instr %0d expected 2 1024 1", n, o_phase_inc, o_instrument);
    end
    tick_once();
    step();
  endtask

  task automatic test_enable_drop();
    int n;
    int s0;
    int st0;
    // Drop in PLAY
    send_note(25, 3, 2);
    wait_start(20, n);
    n_vec++; if (n !== 4 || o_phase_inc !== 16'd4096) begin
      n_err++; $display("FAIL p25: got lat %0d phase %0d expected 4 4096", n, o_phase_inc);
    end
    i_enable = 1'b0;
    step();
    s0 = stb_seen;
    n_vec++; if (o_gate !== 1'b0 || o_phase_inc !== 16'd0) begin
      n_err++; $display("FAIL drop_play: got gate %b phase %0d expected 0 0", o_gate, o_phase_inc);
    end
    repeat (4) step();
    n_vec++; if (stb_seen !== s0) begin
      n_err++; $display("FAIL drop_play_stb: got %0d strobes expected 0", stb_seen - s0);
    end
    i_enable = 1'b1;
    wait_stb(10, n);
    n_vec++; if (n !== 2) begin
      n_err++; $display("FAIL reenable1: got %0d expected 2", n);
    end
    // Phase must hold through the following request
    send_note(37, 0, 4);
    wait_start(20, n);
    tick_once();
    step();
    n_vec++; if (n !== 5 || o_note_stb !== 1'b1 || o_phase_inc !== 16'd8192 || o_instrument !== 4'd4) begin
      n_err++; $display("FAIL hold_p37: got lat %0d stb %b phase %0d instr %0d expected 5 1 8192 4", n, o_note_stb, o_phase_inc, o_instrument);
    end
    // Drop in DECODE
    send_note(49, 0, 6);
    step();
    i_enable = 1'b0;
    st0 = start_seen;
    step();
    n_vec++; if (o_phase_inc !== 16'd0 || o_gate !== 1'b0) begin
      n_err++; $display("FAIL drop_decode: got phase %0d gate %b expected 0 0", o_phase_inc, o_gate);
    end
    repeat (6) step();
    n_vec++; if (start_seen !== st0 || o_instrument !== 4'd4) begin
      n_err++; $display("FAIL decode_aborted: got starts %0d instr %0d expected 0 4", start_seen - st0, o_instrument);
    end
    i_enable = 1'b1;
    wait_stb(10, n);
    n_vec++; if (n !== 2) begin
      n_err++; $display("FAIL reenable2: got %0d expected 2", n);
    end
    // Drop together with the final tick
    send_note(2, 0, 7);
    wait_start(20, n);
    n_vec++; if (n !== 2 || o_phase_inc !== 16'd1084 || o_gate !== 1'b1) begin
      n_err++; $display("FAIL p2: got lat %0d phase %0d gate %b expected 2 1084 1", n, o_phase_inc, o_gate);
    end
    i_enable = 1'b0;
    tick_once();
    s0 = stb_seen;
    n_vec++; if (o_gate !== 1'b0 || o_phase_inc !== 16'd0) begin
      n_err++; $display("FAIL drop_tick: got gate %b phase %0d expected 0 0", o_gate, o_phase_inc);
    end
    repeat (4) step();
    n_vec++; if (stb_seen !== s0) begin
      n_err++; $display("FAIL drop_tick_stb: got %0d strobes expected 0", stb_seen - s0);
    end
    i_enable = 1'b1;
    wait_stb(10, n);
    n_vec++; if (n !== 2) begin
      n_err++; $display("FAIL reenable3: got %0d expected 2", n);
    end
    // Synchronous reset while playing
    send_note(13, 0, 5);
    wait_start(20, n);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    n_vec++; if (o_gate !== 1'b0 || o_phase_inc !== 16'd0 || o_instrument !== 4'd0 || o_note_start !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got gate %b phase %0d instr %0d start %b expected 0 0 0 0", o_gate, o_phase_inc, o_instrument, o_note_start);
    end
    wait_stb(10, n);
    n_vec++; if (n !== 2) begin
      n_err++; $display("FAIL reset_restart: got %0d expected 2", n);
    end
  endtask

  task automatic test_back_to_back();
    int pitches [8] = '{5, 17, 29, 0, 41, 53, 62, 12};
    int lens    [8] = '{0, 1, 2, 0, 1, 0, 2, 1};
    int n;
    int ticks;
    int got;
    int s0;
    int t0;
    s0 = stb_seen;
    t0 = to_seen;
    for (int i = 0; i < 8; i++) begin
      repeat (3 + (i % 2)) step();
      send_note(pitches[i], lens[i], i + 1);
      wait_start(12, n);
      n_vec++; if (n !== exp_lat(pitches[i]) || o_phase_inc !== exp_phase(pitches[i]) || o_instrument !== 4'(i + 1)) begin
        n_err++; $display("FAIL seq_note%0d: got lat %0d phase %0d instr %0d expected %0d %0d %0d", i, n, o_phase_inc, o_instrument, exp_lat(pitches[i]), exp_phase(pitches[i]), i + 1);
      end
      ticks = 0;
      got = 0;
      for (int k = 0; k < 40 && got == 0; k++) begin
        tick_once();
        ticks++;
        step();
        if (o_note_stb === 1'b1) got = 1;
      end
      n_vec++; if (got !== 1 || ticks !== lens[i] + 1) begin
        n_err++; $display("FAIL seq_dur%0d: got %0d ticks (stb %0d) expected %0d", i, ticks, got, lens[i] + 1);
      end
    end
    n_vec++; if (stb_seen - s0 !== 8 || to_seen !== t0) begin
      n_err++; $display("FAIL seq_counts: got %0d strobes %0d timeouts expected 8 0", stb_seen - s0, to_seen - t0);
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_rest_and_top();
    test_timeout();
    test_enable_drop();
    test_back_to_back();
    i_enable = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
